// File: rtl/modinv_helper_pkg.sv
// Shared constants and write bundle for the modinv precompute helper.
// MODINV_PRECOMPUTE_OUTREG_EN adds one register stage on every write port.
package modinv_helper_pkg;

`ifdef MODINV_PRECOMPUTE_OUTREG_EN
  localparam int OUT_LAT = 1;
`else
  localparam int OUT_LAT = 0;
`endif

  localparam int RD_START    = 1;
  localparam int DP_WR_START = 3;
  localparam int WR_START    = DP_WR_START + OUT_LAT;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int proc_num_cycles(input int n);
    return n + 2 + OUT_LAT;
  endfunction

  function automatic int wr_first_cnt();
    return WR_START;
  endfunction

  function automatic int wr_last_cnt(input int n);
    return n + WR_START - 1;
  endfunction

  typedef struct packed {
    logic [31:0] r_dbl;
    logic [31:0] s_dbl;
    logic [31:0] r_plus_s;
    logic [31:0] u_half;
    logic [31:0] v_half;
    logic [31:0] u_minus_v_half;
    logic [31:0] v_minus_u_half;
  } wr_word_t;

endpackage

// File: rtl/modinv_helper_adder32.sv
// 32-bit adder/subtractor slice; sub=1 computes a + ~b + cin.
module modinv_helper_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] b_eff;
  logic [32:0] total;

  assign b_eff = sub ? ~b : b;
  assign total = {1'b0, a} + {1'b0, b_eff} + {32'd0, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/modinv_helper_invert_precompute.sv
// Word-serial precompute of shifted/summed/differenced operands and flags.
// MODINV_PRECOMPUTE_OUTREG_EN registers the write ports (one extra cycle).
module modinv_helper_invert_precompute
  import modinv_helper_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  output logic                        rdy,
  output logic [BUFFER_ADDR_BITS-1:0] r_addr,
  output logic [BUFFER_ADDR_BITS-1:0] s_addr,
  output logic [BUFFER_ADDR_BITS-1:0] u_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_addr,
  input  logic [31:0]                 r_din,
  input  logic [31:0]                 s_din,
  input  logic [31:0]                 u_din,
  input  logic [31:0]                 v_din,
  output logic [BUFFER_ADDR_BITS-1:0] r_dbl_addr,
  output logic                        r_dbl_wren,
  output logic [31:0]                 r_dbl_dout,
  output logic [BUFFER_ADDR_BITS-1:0] s_dbl_addr,
  output logic                        s_dbl_wren,
  output logic [31:0]                 s_dbl_dout,
  output logic [BUFFER_ADDR_BITS-1:0] r_plus_s_addr,
  output logic                        r_plus_s_wren,
  output logic [31:0]                 r_plus_s_dout,
  output logic [BUFFER_ADDR_BITS-1:0] u_half_addr,
  output logic                        u_half_wren,
  output logic [31:0]                 u_half_dout,
  output logic [BUFFER_ADDR_BITS-1:0] v_half_addr,
  output logic                        v_half_wren,
  output logic [31:0]                 v_half_dout,
  output logic [BUFFER_ADDR_BITS-1:0] u_minus_v_half_addr,
  output logic                        u_minus_v_half_wren,
  output logic [31:0]                 u_minus_v_half_dout,
  output logic [BUFFER_ADDR_BITS-1:0] v_minus_u_half_addr,
  output logic                        v_minus_u_half_wren,
  output logic [31:0]                 v_minus_u_half_dout,
  output logic                        u_gt_v,
  output logic                        v_eq_1,
  output logic                        u_is_even,
  output logic                        v_is_even
);

  localparam int N       = BUFFER_NUM_WORDS;
  localparam int AW      = BUFFER_ADDR_BITS;
  localparam int CNT_MAX = proc_num_cycles(N);
  localparam int CW      = clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_MAX   = CW'(CNT_MAX);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_RD_LO = CW'(RD_START);
  localparam logic [CW-1:0] C_RD_HI = CW'(N);
  localparam logic [CW-1:0] C_IN_LO = CW'(RD_START + 1);
  localparam logic [CW-1:0] C_IN_HI = CW'(N + 1);
  localparam logic [CW-1:0] C_WR_LO = CW'(DP_WR_START);
  localparam logic [CW-1:0] C_WR_HI = CW'(N + 2);

  logic [CW-1:0] cnt;
  logic          rd_act;
  logic          in_act;
  logic          wr_act;
  logic          last;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  logic [31:0] r_m, s_m, u_m, v_m;
  logic [31:0] r_cur, s_cur;
  logic [31:1] u_hi, v_hi;
  logic        r_msb, s_msb;

  logic [31:0] rs_sum, rs_res;
  logic        rs_c, rs_co;
  logic [31:1] uv_hi, vu_hi;
  logic [31:0] uv_res, vu_res;
  logic        uv_b, uv_co;
  logic        vu_b, vu_co;

  logic u_ne_v, v_ne1, u_lsb, v_lsb;

  wr_word_t      wd;
  wr_word_t      wo;
  logic          wo_en;
  logic [AW-1:0] wo_addr;

  assign rdy    = (cnt == '0);
  assign rd_act = (cnt >= C_RD_LO) && (cnt <= C_RD_HI);
  assign in_act = (cnt >= C_IN_LO) && (cnt <= C_IN_HI);
  assign wr_act = (cnt >= C_WR_LO) && (cnt <= C_WR_HI);
  assign last   = (cnt == C_WR_HI);
  assign rd_idx = rd_act ? AW'(cnt - C_RD_LO) : '0;
  assign wr_idx = wr_act ? AW'(cnt - C_WR_LO) : '0;

  assign r_addr = rd_idx;
  assign s_addr = rd_idx;
  assign u_addr = rd_idx;
  assign v_addr = rd_idx;

  // Word N does not exist: feed zeros outside the read-data window.
  assign r_m = in_act ? r_din : '0;
  assign s_m = in_act ? s_din : '0;
  assign u_m = in_act ? u_din : '0;
  assign v_m = in_act ? v_din : '0;

  modinv_helper_adder32 u_add_rs (
    .a(r_m), .b(s_m), .sub(1'b0), .cin(rs_c),
    .sum(rs_res), .cout(rs_co)
  );

  modinv_helper_adder32 u_sub_uv (
    .a(u_m), .b(v_m), .sub(1'b1), .cin(~uv_b),
    .sum(uv_res), .cout(uv_co)
  );

  modinv_helper_adder32 u_sub_vu (
    .a(v_m), .b(u_m), .sub(1'b1), .cin(~vu_b),
    .sum(vu_res), .cout(vu_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      r_cur     <= '0;
      s_cur     <= '0;
      u_hi      <= '0;
      v_hi      <= '0;
      r_msb     <= 1'b0;
      s_msb     <= 1'b0;
      rs_sum    <= '0;
      rs_c      <= 1'b0;
      uv_hi     <= '0;
      uv_b      <= 1'b0;
      vu_hi     <= '0;
      vu_b      <= 1'b0;
      u_ne_v    <= 1'b0;
      v_ne1     <= 1'b0;
      u_lsb     <= 1'b0;
      v_lsb     <= 1'b0;
      u_gt_v    <= 1'b0;
      v_eq_1    <= 1'b0;
      u_is_even <= 1'b0;
      v_is_even <= 1'b0;
    end else begin
      if (cnt == '0) begin
        if (ena) cnt <= C_ONE;
      end else if (cnt == C_MAX) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + C_ONE;
      end

      if (cnt == C_ONE) begin
        r_cur  <= '0;
        s_cur  <= '0;
        u_hi   <= '0;
        v_hi   <= '0;
        r_msb  <= 1'b0;
        s_msb  <= 1'b0;
        rs_sum <= '0;
        rs_c   <= 1'b0;
        uv_hi  <= '0;
        uv_b   <= 1'b0;
        vu_hi  <= '0;
        vu_b   <= 1'b0;
        u_ne_v <= 1'b0;
        v_ne1  <= 1'b0;
        u_lsb  <= 1'b0;
        v_lsb  <= 1'b0;
      end else if (in_act) begin
        r_msb  <= r_cur[31];
        s_msb  <= s_cur[31];
        r_cur  <= r_m;
        s_cur  <= s_m;
        u_hi   <= u_m[31:1];
        v_hi   <= v_m[31:1];
        rs_sum <= rs_res;
        rs_c   <= rs_co;
        uv_hi  <= uv_res[31:1];
        uv_b   <= ~uv_co;
        vu_hi  <= vu_res[31:1];
        vu_b   <= ~vu_co;
        u_ne_v <= u_ne_v | (u_m != v_m);
        v_ne1  <= v_ne1 | (v_m != ((cnt == C_IN_LO) ? 32'd1 : 32'd0));
        if (cnt == C_IN_LO) begin
          u_lsb <= u_m[0];
          v_lsb <= v_m[0];
        end
      end

      if (cnt == C_MAX) begin
        u_gt_v    <= ~uv_b & u_ne_v;
        v_eq_1    <= ~v_ne1;
        u_is_even <= ~u_lsb;
        v_is_even <= ~v_lsb;
      end
    end
  end

  // Right shifts borrow bit 0 of the next word; left shifts the saved MSB.
  always_comb begin
    wd                = '0;
    wd.r_dbl          = {r_cur[30:0], r_msb};
    wd.s_dbl          = {s_cur[30:0], s_msb};
    wd.r_plus_s       = rs_sum;
    wd.u_half         = {u_m[0], u_hi};
    wd.v_half         = {v_m[0], v_hi};
    wd.u_minus_v_half = {last ? 1'b0 : uv_res[0], uv_hi};
    wd.v_minus_u_half = {last ? 1'b0 : vu_res[0], vu_hi};
  end

`ifdef MODINV_PRECOMPUTE_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wo      <= '0;
      wo_en   <= 1'b0;
      wo_addr <= '0;
    end else begin
      wo      <= wd;
      wo_en   <= wr_act;
      wo_addr <= wr_idx;
    end
  end
`else
  assign wo      = wd;
  assign wo_en   = wr_act;
  assign wo_addr = wr_idx;
`endif

  assign r_dbl_addr          = wo_addr;
  assign r_dbl_wren          = wo_en;
  assign r_dbl_dout          = wo.r_dbl;
  assign s_dbl_addr          = wo_addr;
  assign s_dbl_wren          = wo_en;
  assign s_dbl_dout          = wo.s_dbl;
  assign r_plus_s_addr       = wo_addr;
  assign r_plus_s_wren       = wo_en;
  assign r_plus_s_dout       = wo.r_plus_s;
  assign u_half_addr         = wo_addr;
  assign u_half_wren         = wo_en;
  assign u_half_dout         = wo.u_half;
  assign v_half_addr         = wo_addr;
  assign v_half_wren         = wo_en;
  assign v_half_dout         = wo.v_half;
  assign u_minus_v_half_addr = wo_addr;
  assign u_minus_v_half_wren = wo_en;
  assign u_minus_v_half_dout = wo.u_minus_v_half;
  assign v_minus_u_half_addr = wo_addr;
  assign v_minus_u_half_wren = wo_en;
  assign v_minus_u_half_dout = wo.v_minus_u_half;

endmodule

// File: tb/tb_modinv_helper_invert_precompute.sv
// Scoreboard bench: directed operands, queued expectations, negedge monitor.
// Honours MODINV_PRECOMPUTE_OUTREG_EN for latency and write-window timing.
module tb_modinv_helper_invert_precompute;

  localparam int N  = 9;
  localparam int AW = 4;
  localparam int W  = 32 * N;
`ifdef MODINV_PRECOMPUTE_OUTREG_EN
  localparam int LAT    = 12;
  localparam int WR_OFF = 3;
`else
  localparam int LAT    = 11;
  localparam int WR_OFF = 2;
`endif

  typedef struct packed {
    logic [W-1:0] rd;
    logic [W-1:0] sd;
    logic [W-1:0] rps;
    logic [W-1:0] uh;
    logic [W-1:0] vh;
    logic [W-1:0] uvh;
    logic [W-1:0] vuh;
    logic [3:0]   fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst, ena, rdy;
  logic [AW-1:0] r_addr, s_addr, u_addr, v_addr;
  logic [31:0]   r_din, s_din, u_din, v_din;
  logic [AW-1:0] rd_a, sd_a, rps_a, uh_a, vh_a, uvh_a, vuh_a;
  logic          rd_w, sd_w, rps_w, uh_w, vh_w, uvh_w, vuh_w;
  logic [31:0]   rd_d, sd_d, rps_d, uh_d, vh_d, uvh_d, vuh_d;
  logic          u_gt_v, v_eq_1, u_is_even, v_is_even;

  logic [31:0] r_mem [16];
  logic [31:0] s_mem [16];
  logic [31:0] u_mem [16];
  logic [31:0] v_mem [16];

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  modinv_helper_invert_precompute #(
    .BUFFER_NUM_WORDS(N), .BUFFER_ADDR_BITS(AW)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .rdy(rdy),
    .r_addr(r_addr), .s_addr(s_addr), .u_addr(u_addr), .v_addr(v_addr),
    .r_din(r_din), .s_din(s_din), .u_din(u_din), .v_din(v_din),
    .r_dbl_addr(rd_a), .r_dbl_wren(rd_w), .r_dbl_dout(rd_d),
    .s_dbl_addr(sd_a), .s_dbl_wren(sd_w), .s_dbl_dout(sd_d),
    .r_plus_s_addr(rps_a), .r_plus_s_wren(rps_w), .r_plus_s_dout(rps_d),
    .u_half_addr(uh_a), .u_half_wren(uh_w), .u_half_dout(uh_d),
    .v_half_addr(vh_a), .v_half_wren(vh_w), .v_half_dout(vh_d),
    .u_minus_v_half_addr(uvh_a), .u_minus_v_half_wren(uvh_w),
    .u_minus_v_half_dout(uvh_d),
    .v_minus_u_half_addr(vuh_a), .v_minus_u_half_wren(vuh_w),
    .v_minus_u_half_dout(vuh_d),
    .u_gt_v(u_gt_v), .v_eq_1(v_eq_1),
    .u_is_even(u_is_even), .v_is_even(v_is_even)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    r_din <= r_mem[r_addr];
    s_din <= s_mem[s_addr];
    u_din <= u_mem[u_addr];
    v_din <= v_mem[v_addr];
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] wrens();
    return {rd_w, sd_w, rps_w, uh_w, vh_w, uvh_w, vuh_w};
  endfunction

  // Monitor: captures writes and scores each completed operation.
  bit           busy = 0;
  int           t0, wr_full, wr_any, wr_first;
  logic [W-1:0] c_rd, c_sd, c_rps, c_uh, c_vh, c_uvh, c_vuh;

  always @(negedge clk) begin
    logic [6:0] wv;
    exp_t       e;
    wv = wrens();
    if (rst) begin
      busy = 0;
    end else begin
      if (!busy && !rdy) begin
        busy = 1;
        t0 = cyc;
        wr_full = 0;
        wr_any = 0;
        wr_first = -1;
        c_rd = {N{32'hA5A5A5A5}};
        c_sd = c_rd; c_rps = c_rd; c_uh = c_rd;
        c_vh = c_rd; c_uvh = c_rd; c_vuh = c_rd;
      end
      if (busy && wv != 7'd0) begin
        wr_any++;
        if (wv == 7'h7F) wr_full++;
        if (wr_first < 0) wr_first = cyc - t0;
        if (rd_w && int'(rd_a) < N) c_rd[int'(rd_a)*32 +: 32] = rd_d;
        if (sd_w && int'(sd_a) < N) c_sd[int'(sd_a)*32 +: 32] = sd_d;
        if (rps_w && int'(rps_a) < N) c_rps[int'(rps_a)*32 +: 32] = rps_d;
        if (uh_w && int'(uh_a) < N) c_uh[int'(uh_a)*32 +: 32] = uh_d;
        if (vh_w && int'(vh_a) < N) c_vh[int'(vh_a)*32 +: 32] = vh_d;
        if (uvh_w && int'(uvh_a) < N) c_uvh[int'(uvh_a)*32 +: 32] = uvh_d;
        if (vuh_w && int'(vuh_a) < N) c_vuh[int'(vuh_a)*32 +: 32] = vuh_d;
      end
      if (busy && rdy) begin
        busy = 0;
        if (q.size() == 0) begin
          chk("unexpected_done", W'(1), W'(0));
        end else begin
          e = q.pop_front();
          chk("r_dbl", c_rd, e.rd);
          chk("s_dbl", c_sd, e.sd);
          chk("r_plus_s", c_rps, e.rps);
          chk("u_half", c_uh, e.uh);
          chk("v_half", c_vh, e.vh);
          chk("u_minus_v_half", c_uvh, e.uvh);
          chk("v_minus_u_half", c_vuh, e.vuh);
          chk("flags", W'({u_gt_v, v_eq_1, u_is_even, v_is_even}), W'(e.fl));
          chk("latency", W'(cyc - t0), W'(LAT));
          chk("wr_first", W'(wr_first), W'(WR_OFF));
          chk("wr_cycles", W'(wr_any), W'(N));
          chk("wr_all7", W'(wr_full), W'(N));
        end
      end
    end
  end

  task automatic wait_rdy();
    int k;
    k = 0;
    while (!rdy && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!rdy) chk("rdy_timeout", W'(rdy), W'(1));
  endtask

  task automatic issue(input logic [W-1:0] r, input logic [W-1:0] s,
                       input logic [W-1:0] u, input logic [W-1:0] v,
                       input exp_t e, input bit push);
    wait_rdy();
    for (int i = 0; i < N; i++) begin
      r_mem[i] = r[i*32 +: 32];
      s_mem[i] = s[i*32 +: 32];
      u_mem[i] = u[i*32 +: 32];
      v_mem[i] = v[i*32 +: 32];
    end
    if (push) q.push_back(e);
    ena = 1'b1;
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  localparam logic [W-1:0] ONES = {N{32'hFFFFFFFF}};
  localparam logic [W-1:0] NEG7H = {32'h7FFFFFFF, {7{32'hFFFFFFFF}}, 32'hFFFFFFFC};

  exp_t e1, e2, e3, e4, e5;

  initial begin
    for (int i = 0; i < 16; i++) begin
      r_mem[i] = '0; s_mem[i] = '0; u_mem[i] = '0; v_mem[i] = '0;
    end
    rst = 1'b1;
    ena = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_rdy", W'(rdy), W'(1));
    chk("reset_wren", W'(wrens()), W'(0));
    chk("reset_flags", W'({u_gt_v, v_eq_1, u_is_even, v_is_even}), W'(0));

    // r=1 s=2 u=10 v=3
    e1 = '{rd: W'(2), sd: W'(4), rps: W'(3), uh: W'(5), vh: W'(1),
           uvh: W'(3), vuh: NEG7H, fl: 4'b1010};
    issue(W'(1), W'(2), W'(10), W'(3), e1, 1);

    // u=v=2^32: cross-word right shift, equal operands
    e2 = '{rd: {32'h1, 32'h0}, sd: W'(6), rps: W'(64'h80000003),
           uh: W'(32'h80000000), vh: W'(32'h80000000),
           uvh: '0, vuh: '0, fl: 4'b0011};
    issue(W'(32'h80000000), W'(3), {32'h1, 32'h0}, {32'h1, 32'h0}, e2, 1);

    // r=s=2^287-1 carry through all words; u=7 v=1
    e3 = '{rd: {ONES[W-1:32], 32'hFFFFFFFE}, sd: {ONES[W-1:32], 32'hFFFFFFFE},
           rps: {ONES[W-1:32], 32'hFFFFFFFE}, uh: W'(3), vh: '0, uvh: W'(3),
           vuh: {32'h7FFFFFFF, {7{32'hFFFFFFFF}}, 32'hFFFFFFFD}, fl: 4'b1100};
    issue({1'b0, ONES[W-2:0]}, {1'b0, ONES[W-2:0]}, W'(7), W'(1), e3, 1);

    // v=2^32+1 is not one; u=2^33
    e4 = '{rd: '0, sd: '0, rps: '0, uh: {32'h1, 32'h0},
           vh: W'(32'h80000000), uvh: W'(32'h7FFFFFFF),
           vuh: {32'h7FFFFFFF, {7{32'hFFFFFFFF}}, 32'h80000000},
           fl: 4'b1010};
    issue('0, '0, {32'h2, 32'h0}, {32'h1, 32'h1}, e4, 1);

    // u<v, r+s carries into word 1
    e5 = '{rd: {32'h1, 32'hFFFFFFFE}, sd: W'(2), rps: {32'h1, 32'h0},
           uh: W'(1), vh: W'(5), uvh: NEG7H, vuh: W'(3), fl: 4'b0001};
    issue(W'(32'hFFFFFFFF), W'(1), W'(3), W'(10), e5, 1);

    // abort at cnt 5
    issue(W'(1), W'(2), W'(10), W'(3), e1, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_rdy", W'(rdy), W'(1));
    chk("abort_wren", W'(wrens()), W'(0));
    chk("abort_flags", W'({u_gt_v, v_eq_1, u_is_even, v_is_even}), W'(0));

    issue(W'(1), W'(2), W'(10), W'(3), e1, 1);

    begin
      int k;
      k = 0;
      while ((q.size() != 0 || busy) && k < 200) begin
        @(posedge clk);
        k++;
      end
      if (q.size() != 0 || busy) chk("drain_timeout", W'(q.size()), W'(0));
    end
    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modinv_helper_invert_precompute.md
MODINV_HELPER_INVERT_PRECOMPUTE -- requirements
Module: modinv_helper_invert_precompute

Interface
REQ-001 SHALL have parameter BUFFER_NUM_WORDS, default 9: operand length in 32-bit words.
REQ-002 SHALL have parameter BUFFER_ADDR_BITS, default 4: word-address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port ena, input, 1: start request, sampled only when idle.
REQ-006 SHALL have port rdy, output, 1: idle and all outputs/flags valid.
REQ-007 SHALL have ports r_addr/s_addr/u_addr/v_addr, output, BUFFER_ADDR_BITS: shared read address for r, s, u, v.
REQ-008 SHALL have ports r_din/s_din/u_din/v_din, input, 32: read data, valid one cycle after address.
REQ-009 SHALL have, for each X of r_dbl, s_dbl, r_plus_s, u_half, v_half, u_minus_v_half, v_minus_u_half: X_addr output BUFFER_ADDR_BITS, X_wren output 1, X_dout output 32 (write port).
REQ-010 SHALL have ports u_gt_v, v_eq_1, u_is_even, v_is_even, output, 1 each: registered flags.

Function
REQ-011 Words SHALL be processed LSW first; counter proc_cnt runs 0 (idle) -> 1..N+2 -> 0, N = BUFFER_NUM_WORDS.
REQ-012 rdy SHALL equal (proc_cnt == 0); ena while !rdy SHALL be ignored.
REQ-013 Read address SHALL be proc_cnt-1 during cnt 1..N, else 0.
REQ-014 All seven write addresses SHALL equal proc_cnt-3 during cnt 3..N+2, else 0; all wren high exactly those N cycles.
REQ-015 Write of word i SHALL use input word i and word i+1; word N treated as all-zero.
REQ-016 r_dbl = r<<1, s_dbl = s<<1, r_plus_s = r+s, each modulo 2^(32N), carry chained word to word.
REQ-017 u_half = u>>1, v_half = v>>1, MSB of top word 0.
REQ-018 u_minus_v_half = (u-v)>>1, v_minus_u_half = (v-u)>>1, borrow chained, top-word MSB 0 (result valid only when minuend larger).
REQ-019 u_is_even = !u[0], v_is_even = !v[0]; v_eq_1 = (v == 1); u_gt_v = (no final borrow of u-v) && (u != v).
REQ-020 Flags SHALL update once, on the edge leaving cnt N+2, and hold while busy and idle.
REQ-021 Latency ena-accepted to rdy SHALL be N+2 cycles; a new ena in the rdy cycle SHALL start back-to-back.
REQ-022 Carry/borrow/zero accumulators SHALL clear at cnt 1, independent of prior operation.

Reset
REQ-023 rst SHALL force proc_cnt=0, all four flags=0, accumulators=0, all wren=0 on the next edge.
REQ-024 rst mid-operation SHALL abort; partial buffer writes stay, no further wren, flags return to 0.

Configuration
REQ-025 Macro MODINV_PRECOMPUTE_OUTREG_EN defined: X_addr/X_wren/X_dout SHALL pass through one extra register; write window cnt 4..N+3; counter max N+3; latency N+3.
REQ-026 Macro undefined: write outputs combinational from datapath registers per REQ-014; latency N+2.

Structure
REQ-027 Shared include modinv_helper_pkg SHALL hold clog2 and PROC_NUM_CYCLES/write-window constants, with and without the macro.
REQ-028 One sub-module modinv_helper_adder32 (32-bit add/subtract, carry in/out) SHALL be instanced three times (r+s, u-v, v-u).

Verification
REQ-029 N=9, r=1, s=2, u=10, v=3 -> r_dbl=2, s_dbl=4, r_plus_s=3, u_half=5, v_half=1, u_minus_v_half=3; u_gt_v=1, u_is_even=1, v_is_even=0, v_eq_1=0; rdy returns 11 cycles after ena.
REQ-030 u=v=0x1_00000000 (word1=1) -> u_gt_v=0, u_minus_v_half=0, u_half word0=0x80000000; cross-word bit moves correctly.
REQ-031 r=s=2^287-1 (top word 0x7FFFFFFF, rest all-ones) -> r_dbl all-ones except bit0=0; r_plus_s identical; carry propagates through all 9 words.
REQ-032 v=1, u=7 -> v_eq_1=1, u_gt_v=1; v=0x1_00000001 -> v_eq_1=0.
REQ-033 rst asserted at cnt 5 -> next cycle rdy=1, all wren=0, flags=0; following ena completes normally.
REQ-034 With MODINV_PRECOMPUTE_OUTREG_EN: repeat REQ-029 -> identical data, wren window shifted +1, rdy after 12 cycles.
